decoder2_4_seq: RTL and testbench
=================================

DECODER2_4_SEQ -- requirements
Module: decoder2_4_seq

Interface
REQ-001 Parameter HOLD, default 4, cycles the one-hot output is held per accepted code (legal 1..255).
REQ-002 Parameter GAP, default 1, idle cycles forced after each hold (legal 0..255).
REQ-003 Parameter CW, default 8, width of the per-line event counters.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Y  input  2  encoded line index (priority-encoder output format).
REQ-007 valid  input  1  Y is meaningful this cycle.
REQ-008 ready  output  1  block can accept a code this cycle.
REQ-009 D  output  4  registered one-hot decoded line, 4'b0000 when not driving.
REQ-010 active  output  1  high while D is non-zero.
REQ-011 cnt_sel  input  2  selects which line counter appears on cnt_q.
REQ-012 cnt_clr  input  1  synchronous clear of all four counters.
REQ-013 cnt_q  output  CW  event count of line cnt_sel, combinational mux of registers.

Function
REQ-014 FSM states SHALL be IDLE, HOLD_ST, GAP_ST.
REQ-015 ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with valid=1 and ready=1.
REQ-016 On transfer: Y captured, state -> HOLD_ST, D = 1<<Y from the next cycle (latency 1 cycle), hold counter loaded.
REQ-017 D SHALL stay exactly 1<<Y_captured for HOLD consecutive cycles; Y/valid changes during HOLD_ST are ignored.
REQ-018 After HOLD cycles: GAP>0 -> GAP_ST with D=0 for GAP cycles then IDLE; GAP=0 -> directly IDLE.
REQ-019 Back-to-back throughput with GAP=0: a new transfer possible every HOLD+1 cycles (one IDLE cycle minimum).
REQ-020 valid=0 in IDLE: D=0, state unchanged; Y ignored.
REQ-021 Each transfer SHALL increment counter[Y] by 1, saturating at 2^CW-1 (no wrap).
REQ-022 cnt_clr=1 SHALL zero all counters next edge; clear wins over a same-cycle increment.
REQ-023 active SHALL equal |D, registered alongside D.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, D=0, active=0, ready=1 (after release), counters=0, captured Y=0.
REQ-025 Reset mid-HOLD or mid-GAP SHALL abort the sequence without completing remaining cycles.
REQ-026 First transfer possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package decoder_pkg SHALL hold the FSM state enum and the one-hot decode function constant table.
REQ-028 One sub-module, sat_counter (CW-bit saturating counter with inc/clr), instantiated four times.
REQ-029 No latches; all outputs except cnt_q registered.

Verification
REQ-030 Reset then valid=1,Y=2'b10 one cycle -> D=4'b0100 for 4 cycles starting next cycle, then D=0 1 cycle, ready back to 1.
REQ-031 Y=2'b11 accepted, Y toggled to 2'b00 during hold -> D stays 4'b1000 all 4 cycles; counter[0] unchanged.
REQ-032 GAP=0, HOLD=1, valid held high with Y=01 -> D=0010 every other cycle, counter[1]=number of pulses.
REQ-033 CW=2, 5 transfers on Y=00 -> cnt_sel=00 gives cnt_q=3 (saturated); cnt_clr with simultaneous transfer -> 0.
REQ-034 rst_n pulsed low mid-HOLD -> D=0, active=0 asynchronously; ready=1 after release, counters 0.
REQ-035 valid=0 for 10 cycles from IDLE -> D=0, ready=1, counters unchanged throughout.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 2-to-4 decoder:
// FSM state encoding and the one-hot decode table.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_ST = 2'd1,
        GAP_ST  = 2'd2
    } state_e;

    localparam logic [3:0] ONEHOT_TBL [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    function automatic logic [3:0] decode_onehot(input logic [1:0] y);
        return ONEHOT_TBL[y];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// CW-bit event counter that saturates at all-ones; a synchronous clear
// takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] ONE      = 1;
    localparam logic [CW-1:0] ALL_ONES = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != ALL_ONES)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/decoder2_4_seq.sv
// Handshaked 2-to-4 decoder: each accepted code drives a registered one-hot
// output for HOLD cycles, then forces GAP idle cycles; per-line event counters.
module decoder2_4_seq
    import decoder_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    Y,
    input  logic          valid,
    output logic          ready,
    output logic [3:0]    D,
    output logic          active,
    input  logic [1:0]    cnt_sel,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt_q
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);
    localparam logic [7:0] ONE8      = 8'd1;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] y_q, y_d;
    logic [3:0] d_q, d_d;
    logic       active_q, active_d;
    logic       ready_q, ready_d;
    logic       transfer;

    assign transfer = valid && ready_q;

    // State register. NOTE: the reset branch clears every flop, including
    // the captured code, so an aborted sequence leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            y_q      <= '0;
            d_q      <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            y_q      <= y_d;
            d_q      <= d_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    // One shared down-timer counts the remaining hold or gap cycles.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = HOLD_ST;
                    timer_d = HOLD_LOAD;
                    y_d     = Y;
                end
            end
            HOLD_ST: begin
                if (timer_q == '0) begin
                    if (GAP > 0) begin
                        state_d = GAP_ST;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - ONE8;
                end
            end
            GAP_ST: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - ONE8;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        d_d      = (state_d == HOLD_ST) ? decode_onehot(y_d) : 4'b0000;
        active_d = |d_d;
        ready_d  = (state_d == IDLE);
    end

    assign D      = d_q;
    assign active = active_q;
    assign ready  = ready_q;

    logic [CW-1:0] line_cnt [4];

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        sat_counter #(.CW(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (transfer && (Y == 2'(i))),
            .clr_i (cnt_clr),
            .cnt_o (line_cnt[i])
        );
    end

    assign cnt_q = line_cnt[cnt_sel];

endmodule

// File: tb/tb_decoder2_4_seq.sv
// Self-checking bench: scoreboard of expected per-cycle outputs for a default
// instance, plus direct checks on a HOLD=1/GAP=0/CW=2 instance.
module tb_decoder2_4_seq;

    localparam int A_HOLD = 4;
    localparam int A_GAP  = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] a_y, a_sel, b_y, b_sel;
    logic       a_valid, a_clr, a_ready, a_active;
    logic       b_valid, b_clr, b_ready, b_active;
    logic [3:0] a_d, b_d;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    decoder2_4_seq #(.HOLD(A_HOLD), .GAP(A_GAP), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .Y(a_y), .valid(a_valid), .ready(a_ready),
        .D(a_d), .active(a_active), .cnt_sel(a_sel), .cnt_clr(a_clr), .cnt_q(a_cnt)
    );

    decoder2_4_seq #(.HOLD(1), .GAP(0), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .Y(b_y), .valid(b_valid), .ready(b_ready),
        .D(b_d), .active(b_active), .cnt_sel(b_sel), .cnt_clr(b_clr), .cnt_q(b_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] d;
        logic       act;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   cnt_a [4];

    // Scoreboard monitor: one expected entry per cycle after each transfer.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_d", a_d, e.d);
            check("sb_active", a_active, e.act);
            check("sb_ready", a_ready, e.rdy);
        end
    end

    task automatic push_a(input logic [1:0] y);
        logic [3:0] oh;
        oh = 4'b0001 << y;
        for (int i = 0; i < A_HOLD; i++) sb.push_back('{d: oh, act: 1'b1, rdy: 1'b0});
        for (int i = 0; i < A_GAP; i++)  sb.push_back('{d: 4'b0000, act: 1'b0, rdy: 1'b0});
        sb.push_back('{d: 4'b0000, act: 1'b0, rdy: 1'b1});
        if (cnt_a[y] < 255) cnt_a[y]++;
    endtask

    task automatic send_a(input logic [1:0] y, input bit noise);
        int n;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", a_ready, 1'b1);
        a_valid = 1'b1;
        a_y     = y;
        @(posedge clk);
        push_a(y);
        if (noise) begin
            for (int i = 0; i < A_HOLD; i++) begin
                @(negedge clk);
                a_y = 2'b00;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic drain_sb();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), 0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_cnts_a();
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            #1;
            check($sformatf("a_cnt%0d", i), a_cnt, cnt_a[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) cnt_a[i] = 0;
        rst_n   = 1'b0;
        a_valid = 1'b1;
        a_y     = 2'b10;
        a_sel   = 2'b00;
        a_clr   = 1'b0;
        b_valid = 1'b0;
        b_y     = 2'b00;
        b_sel   = 2'b00;
        b_clr   = 1'b0;

        // Reset state
        #3;
        check("rst_d", a_d, 4'b0000);
        check("rst_active", a_active, 1'b0);
        check_cnts_a();
        #5;
        rst_n = 1'b1;
        #1;
        check("rst_ready", a_ready, 1'b1);

        // First transfer on the first edge after release, Y=10
        @(posedge clk);
        push_a(2'b10);
        @(negedge clk);
        a_valid = 1'b0;

        // Y changes during hold are ignored
        send_a(2'b11, 1'b1);
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        drain_sb();
        check_cnts_a();

        // Idle with valid low
        a_y = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_d", a_d, 4'b0000);
            check("idle_ready", a_ready, 1'b1);
        end
        @(posedge clk);
        #2;
        check_cnts_a();

        // Reset in the middle of a hold
        @(negedge clk);
        a_valid = 1'b1;
        a_y     = 2'b01;
        @(negedge clk);
        a_valid = 1'b0;
        check("pre_rst_d", a_d, 4'b0010);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) cnt_a[i] = 0;
        #1;
        check("async_rst_d", a_d, 4'b0000);
        check("async_rst_active", a_active, 1'b0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_d", a_d, 4'b0000);
            check("post_rst_ready", a_ready, 1'b1);
        end
        @(posedge clk);
        #2;
        check_cnts_a();

        // HOLD=1, GAP=0: valid held high gives a pulse every other cycle
        @(negedge clk);
        b_valid = 1'b1;
        b_y     = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("b_pulse_d", b_d, (i % 2 == 1) ? 4'b0010 : 4'b0000);
            check("b_pulse_active", b_active, (i % 2 == 1) ? 1'b1 : 1'b0);
        end
        b_valid = 1'b0;
        b_sel   = 2'b01;
        #1;
        check("b_cnt1_pulses", b_cnt, 2'd3);

        // Five transfers on line 0 saturate a 2-bit counter at 3
        @(negedge clk);
        b_valid = 1'b1;
        b_y     = 2'b00;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        b_valid = 1'b0;
        b_sel   = 2'b00;
        #1;
        check("b_cnt0_sat", b_cnt, 2'd3);

        // Clear wins over a simultaneous transfer
        @(negedge clk);
        check("b_clr_ready", b_ready, 1'b1);
        b_valid = 1'b1;
        b_clr   = 1'b1;
        b_y     = 2'b00;
        @(negedge clk);
        b_valid = 1'b0;
        b_clr   = 1'b0;
        check("b_clr_d", b_d, 4'b0001);
        check("b_clr_cnt0", b_cnt, 2'd0);
        b_sel = 2'b01;
        #1;
        check("b_clr_cnt1", b_cnt, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
